// File: rtl/vga_fill_arbiter.sv
// vga_fill_arbiter
//   Owns the single write port of the VGA video memory and shares it between
//   the CPU VGA instruction (always wins) and a rectangle-fill engine that
//   paints an inclusive rectangle one cell per cycle in raster order.
//
//   Optional feature: define VGA_FILL_ABORT_EN to add iFillAbort, which
//   cancels a pending/running fill (CHECK or FILL) without done/err pulses.
//
// Ports
//   Clock, Reset      clock, asynchronous active-high reset
//   iCpuWrite/Addr/Data  CPU write request (single cycle)
//   iFillStart        fill request, only sampled in IDLE
//   iFillX0/X1/Y0/Y1  inclusive rectangle bounds (4 bits each)
//   iFillColor        fill colour
//   iFillAbort        (VGA_FILL_ABORT_EN only) cancel fill
//   oWriteEnable/Addr/Data  registered VGA RAM write port
//   oFillBusy         high while in CHECK or FILL
//   oFillDone         one-cycle pulse in DONE (coincides with last pixel)
//   oFillErr          one-cycle pulse after a rejected rectangle
//
// MEM_WIDTH*MEM_HEIGHT must not exceed 2**ADDR_WIDTH.
module vga_fill_arbiter #(
  parameter int MEM_WIDTH  = 16,
  parameter int MEM_HEIGHT = 12,
  parameter int DATA_WIDTH = 3,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iCpuWrite,
  input  logic [ADDR_WIDTH-1:0] iCpuAddr,
  input  logic [DATA_WIDTH-1:0] iCpuData,
  input  logic                  iFillStart,
  input  logic [3:0]            iFillX0,
  input  logic [3:0]            iFillX1,
  input  logic [3:0]            iFillY0,
  input  logic [3:0]            iFillY1,
  input  logic [DATA_WIDTH-1:0] iFillColor,
`ifdef VGA_FILL_ABORT_EN
  input  logic                  iFillAbort,
`endif
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddr,
  output logic [DATA_WIDTH-1:0] oWriteData,
  output logic                  oFillBusy,
  output logic                  oFillDone,
  output logic                  oFillErr
);

  typedef enum logic [1:0] {IDLE, CHECK, FILL, DONE} state_t;

  state_t                state;
  logic [3:0]            fillX0, fillX1, fillY0, fillY1;
  logic [DATA_WIDTH-1:0] fillColor;
  logic [3:0]            curX, curY;

  logic                  abort;
  logic                  rectBad;
  logic                  lastPix;
  logic [ADDR_WIDTH-1:0] pixAddr;

`ifdef VGA_FILL_ABORT_EN
  assign abort = iFillAbort;
`else
  assign abort = 1'b0;
`endif

  assign rectBad = (fillX1 < fillX0) || (fillY1 < fillY0) ||
                   (int'(fillX1) >= MEM_WIDTH) || (int'(fillY1) >= MEM_HEIGHT);

  assign lastPix = (curX == fillX1) && (curY == fillY1);

  // Accepted rectangles keep y*MEM_WIDTH+x inside the memory, so the
  // ADDR_WIDTH-bit arithmetic never wraps.
  assign pixAddr = ADDR_WIDTH'(curY) * ADDR_WIDTH'(MEM_WIDTH) + ADDR_WIDTH'(curX);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      fillX0       <= '0;
      fillX1       <= '0;
      fillY0       <= '0;
      fillY1       <= '0;
      fillColor    <= '0;
      curX         <= '0;
      curY         <= '0;
      oWriteEnable <= 1'b0;
      oWriteAddr   <= '0;
      oWriteData   <= '0;
      oFillBusy    <= 1'b0;
      oFillDone    <= 1'b0;
      oFillErr     <= 1'b0;
    end else begin
      // Default: CPU request passes straight through. Only a granted fill
      // pixel overrides this.
      oWriteEnable <= iCpuWrite;
      oWriteAddr   <= iCpuAddr;
      oWriteData   <= iCpuData;
      oFillDone    <= 1'b0;
      oFillErr     <= 1'b0;

      case (state)
        IDLE: begin
          if (iFillStart) begin
            fillX0    <= iFillX0;
            fillX1    <= iFillX1;
            fillY0    <= iFillY0;
            fillY1    <= iFillY1;
            fillColor <= iFillColor;
            state     <= CHECK;
            oFillBusy <= 1'b1;
          end
        end

        CHECK: begin
          if (abort) begin
            state     <= IDLE;
            oFillBusy <= 1'b0;
          end else if (rectBad) begin
            state     <= IDLE;
            oFillBusy <= 1'b0;
            oFillErr  <= 1'b1;
          end else begin
            curX  <= fillX0;
            curY  <= fillY0;
            state <= FILL;
          end
        end

        FILL: begin
          if (abort) begin
            // CPU write (if any) still goes out via the default above.
            state     <= IDLE;
            oFillBusy <= 1'b0;
          end else if (!iCpuWrite) begin
            oWriteEnable <= 1'b1;
            oWriteAddr   <= pixAddr;
            oWriteData   <= fillColor;
            if (lastPix) begin
              state     <= DONE;
              oFillBusy <= 1'b0;
              oFillDone <= 1'b1;
            end else if (curX == fillX1) begin
              curX <= fillX0;
              curY <= curY + 4'd1;
            end else begin
              curX <= curX + 4'd1;
            end
          end
          // CPU granted: cursor holds, CPU write passes through.
        end

        DONE: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fill_arbiter.sv
module tb_vga_fill_arbiter;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       iCpuWrite = 1'b0;
  logic [7:0] iCpuAddr = '0;
  logic [2:0] iCpuData = '0;
  logic       iFillStart = 1'b0;
  logic [3:0] iFillX0 = '0, iFillX1 = '0, iFillY0 = '0, iFillY1 = '0;
  logic [2:0] iFillColor = '0;
`ifdef VGA_FILL_ABORT_EN
  logic       iFillAbort = 1'b0;
`endif
  logic       oWriteEnable;
  logic [7:0] oWriteAddr;
  logic [2:0] oWriteData;
  logic       oFillBusy, oFillDone, oFillErr;

  vga_fill_arbiter dut (
    .Clock(Clock), .Reset(Reset),
    .iCpuWrite(iCpuWrite), .iCpuAddr(iCpuAddr), .iCpuData(iCpuData),
    .iFillStart(iFillStart), .iFillX0(iFillX0), .iFillX1(iFillX1),
    .iFillY0(iFillY0), .iFillY1(iFillY1), .iFillColor(iFillColor),
`ifdef VGA_FILL_ABORT_EN
    .iFillAbort(iFillAbort),
`endif
    .oWriteEnable(oWriteEnable), .oWriteAddr(oWriteAddr), .oWriteData(oWriteData),
    .oFillBusy(oFillBusy), .oFillDone(oFillDone), .oFillErr(oFillErr)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int addr;
    int data;
    bit done;
    int cyc;
  } exp_t;

  exp_t expQ[$];
  int   cyc = 0;
  int   total = 0, passed = 0;
  int   errCnt = 0, doneCnt = 0, busyCnt = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
  endtask

  // Monitor: every write on the port must match the head of the scoreboard.
  always @(negedge Clock) begin
    if (!Reset) begin
      if (oFillErr)  errCnt++;
      if (oFillDone) doneCnt++;
      if (oFillBusy) busyCnt++;
      if (oWriteEnable) begin
        if (expQ.size() == 0) begin
          chk("unexpected_write_addr", int'(oWriteAddr), -1);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          chk("wr_addr", int'(oWriteAddr), e.addr);
          chk("wr_data", int'(oWriteData), e.data);
          chk("wr_done", int'(oFillDone), int'(e.done));
          chk("wr_cycle", cyc, e.cyc);
        end
      end else if (oFillDone) begin
        chk("done_without_write", 0, 1);
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Drive a CPU request for the next edge; a write is expected one edge later.
  task automatic cpuDrive(input bit wr, input int addr, input int data);
    exp_t e;
    iCpuWrite = wr;
    iCpuAddr  = 8'(addr);
    iCpuData  = 3'(data);
    if (wr) begin
      e.addr = addr; e.data = data; e.done = 1'b0; e.cyc = cyc + 1;
      expQ.push_back(e);
    end
  endtask

  task automatic cpuRand(input int pct);
    cpuDrive($urandom_range(99) < pct, int'($urandom_range(255)), int'($urandom_range(7)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      iFillStart = 1'b0;
      cpuDrive(1'b0, 0, 0);
      step();
    end
  endtask

  // Full fill scenario. forceIdx >= 0 forces a CPU write 200/7 in that FILL
  // cycle; abortAfter >= 0 aborts once that many pixels were issued.
  task automatic runFill(input int x0, input int x1, input int y0, input int y1,
                         input int col, input int pct, input int forceIdx,
                         input bit spur, input int abortAfter, input string tag);
    int  pix[$];
    bit  valid;
    int  nCpu, popped, fcyc, e0, d0, b0;
    exp_t e;
    valid = (x0 <= x1) && (y0 <= y1) && (x1 < 16) && (y1 < 12);
    if (valid)
      for (int y = y0; y <= y1; y++)
        for (int x = x0; x <= x1; x++)
          pix.push_back(y * 16 + x);
    e0 = errCnt; d0 = doneCnt; b0 = busyCnt;
    nCpu = 0; popped = 0; fcyc = 0;

    iFillStart = 1'b1;
    iFillX0 = 4'(x0); iFillX1 = 4'(x1); iFillY0 = 4'(y0); iFillY1 = 4'(y1);
    iFillColor = 3'(col);
    cpuRand(pct);
    step();                       // start sampled
    iFillStart = 1'b0;
    cpuRand(pct);
    step();                       // CHECK resolves

    if (valid) begin
      while (pix.size() > 0) begin
        iFillStart = spur ? 1'b1 : 1'b0;
        iFillX0 = 4'($urandom_range(15)); iFillX1 = 4'd15;
        iFillY0 = 4'($urandom_range(11)); iFillY1 = 4'd11;
        iFillColor = 3'($urandom_range(7));
        if (fcyc == forceIdx) cpuDrive(1'b1, 200, 7);
        else cpuRand(pct);
`ifdef VGA_FILL_ABORT_EN
        if (abortAfter >= 0 && popped == abortAfter) begin
          if (iCpuWrite) nCpu++;
          iFillAbort = 1'b1;
          step();
          iFillAbort = 1'b0;
          break;
        end
`endif
        if (iCpuWrite) nCpu++;
        else begin
          e.addr = pix.pop_front(); e.data = col;
          e.done = (pix.size() == 0); e.cyc = cyc + 1;
          expQ.push_back(e);
          popped++;
        end
        fcyc++;
        step();
      end
      if (abortAfter < 0) begin
        iFillStart = 1'b0;
        cpuRand(pct);             // DONE cycle: CPU still passes through
        step();
      end
    end
    idle(3);
    chk({tag, "_err"},  errCnt - e0,  valid ? 0 : 1);
    chk({tag, "_done"}, doneCnt - d0, (valid && abortAfter < 0) ? 1 : 0);
    if (!valid)
      chk({tag, "_busy"}, busyCnt - b0, 1);
    else if (abortAfter < 0)
      chk({tag, "_busy"}, busyCnt - b0, 1 + popped + nCpu);
    else
      chk({tag, "_busy"}, busyCnt - b0, 2 + popped + nCpu);
    chk({tag, "_queue_empty"}, expQ.size(), 0);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 400000", cyc);
    $fatal(1);
  end

  initial begin
    int x0, x1, y0, y1, t;
    #1;
    chk("rst_we",   int'(oWriteEnable), 0);
    chk("rst_addr", int'(oWriteAddr), 0);
    chk("rst_data", int'(oWriteData), 0);
    chk("rst_busy", int'(oFillBusy), 0);
    chk("rst_done", int'(oFillDone), 0);
    chk("rst_err",  int'(oFillErr), 0);
    step(); step();
    Reset = 1'b0;
    idle(2);

    runFill(0, 15, 0, 11, 5, 0, -1, 1'b0, -1, "full");
    runFill(3, 4, 4, 5, 2, 0, -1, 1'b0, -1, "rect2x2");
    runFill(3, 4, 4, 5, 2, 0, 1, 1'b0, -1, "contend");
    runFill(2, 5, 3, 12, 1, 60, -1, 1'b0, -1, "bad_y1");
    runFill(2, 5, 7, 3, 1, 60, -1, 1'b0, -1, "bad_yorder");
    runFill(9, 4, 0, 1, 1, 60, -1, 1'b0, -1, "bad_xorder");
    runFill(1, 6, 2, 4, 6, 20, -1, 1'b1, -1, "spurstart");
    runFill(15, 15, 11, 11, 3, 0, -1, 1'b0, -1, "corner");
`ifdef VGA_FILL_ABORT_EN
    runFill(0, 15, 0, 11, 4, 0, -1, 1'b0, 3, "abort");
    runFill(0, 1, 0, 0, 6, 0, -1, 1'b0, -1, "after_abort");
`endif

    for (int i = 0; i < 25; i++) begin
      x0 = $urandom_range(15); x1 = $urandom_range(15);
      y0 = $urandom_range(13); y1 = $urandom_range(13);
      if ($urandom_range(3) != 0 && x1 < x0) begin t = x0; x0 = x1; x1 = t; end
      if ($urandom_range(3) != 0 && y1 < y0) begin t = y0; y0 = y1; y1 = t; end
      runFill(x0, x1, y0, y1, int'($urandom_range(7)), 30, -1, 1'b1, -1, "rand");
    end

    // Reset in the middle of a full-screen fill: nothing more may be written.
    iFillStart = 1'b1;
    iFillX0 = 4'd0; iFillX1 = 4'd15; iFillY0 = 4'd0; iFillY1 = 4'd11;
    iFillColor = 3'd6;
    cpuDrive(1'b0, 0, 0);
    step();
    iFillStart = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      e.addr = i; e.data = 6; e.done = 1'b0; e.cyc = cyc + 1;
      expQ.push_back(e);
      step();
    end
    @(negedge Clock);
    #1;
    Reset = 1'b1;
    #1;
    expQ.delete();
    chk("midrst_we",   int'(oWriteEnable), 0);
    chk("midrst_addr", int'(oWriteAddr), 0);
    chk("midrst_busy", int'(oFillBusy), 0);
    chk("midrst_done", int'(oFillDone), 0);
    step(); step();
    Reset = 1'b0;
    idle(4);
    chk("postrst_busy", int'(oFillBusy), 0);
    runFill(7, 8, 1, 1, 2, 0, -1, 1'b0, -1, "postrst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
